ks_byte_cipher: RTL and testbench

- Downstream consumer of the bilateral stop-and-go keystream generator's serial output bit.
- Packs the keystream into bytes and buffers them in a small FIFO.
- XORs each buffered keystream byte with an incoming plaintext or ciphertext byte under a valid/ready handshake.
- Because XOR is symmetric, the same block both encrypts and decrypts; it forms the byte-level stream-cipher datapath.

---
 rtl/ks_byte_cipher_pkg.sv | 7 +
 rtl/ks_fifo.sv | 50 +++++
 rtl/ks_byte_cipher.sv | 81 ++++++++
 tb/tb_ks_byte_cipher.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/ks_byte_cipher_pkg.sv
// Shared constants for the keystream byte cipher datapath.
// Covers the byte width, the packer reset value and the default FIFO depth.
package ks_byte_cipher_pkg;
    localparam int BYTE_W = 8;
    localparam logic [BYTE_W-1:0] SR_RESET = '0;
    localparam int DEPTH_DEFAULT = 4;
endpackage

// File: rtl/ks_fifo.sv
// Small synchronous FIFO holding packed keystream bytes; supports push and pop in one cycle.
// clr empties it synchronously, exactly like rst, so the cipher can resync.
module ks_fifo
    import ks_byte_cipher_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int CW    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              push,
    input  logic [BYTE_W-1:0] push_data,
    input  logic              pop,
    output logic [BYTE_W-1:0] head,
    output logic [CW-1:0]     count,
    output logic              full,
    output logic              empty
);
    localparam int AW = $clog2(DEPTH);

    logic [BYTE_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !clr && push) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
endmodule

// File: rtl/ks_byte_cipher.sv
// Packs serial keystream bits LSB-first into bytes, buffers them, and XORs each
// buffered byte with an incoming data byte. The same path both encrypts and decrypts.
module ks_byte_cipher
    import ks_byte_cipher_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int CW    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ks_bit,
    input  logic              ks_valid,
    input  logic              flush,
    input  logic [BYTE_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic [BYTE_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic [CW-1:0]     fifo_count,
    output logic              ks_drop
);
    logic [BYTE_W-1:0] sr;
    logic [2:0]        bit_cnt;
    logic [BYTE_W-1:0] fifo_head;
    logic [BYTE_W-1:0] next_sr;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic              push;
    logic              accept;
    logic              drop_now;

    // Handshake: a transfer happens on any cycle where valid and ready are both 1;
    // valid never waits for ready, and a held result keeps dout stable until taken.
    assign din_ready = !rst && !flush && !fifo_empty && (!dout_valid || dout_ready);
    assign pop       = din_valid && din_ready;

    // The last bit of a byte is held off only when it has nowhere to go.
    assign accept   = ks_valid && !(bit_cnt == 3'd7 && fifo_full && !pop);
    assign push     = accept && !flush && (bit_cnt == 3'd7);
    assign drop_now = ks_valid && !accept && !flush;
    assign next_sr  = {ks_bit, sr[BYTE_W-1:1]};

    ks_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clr       (flush),
        .push      (push),
        .push_data (next_sr),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            sr         <= SR_RESET;
            bit_cnt    <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            ks_drop    <= 1'b0;
        end else begin
            ks_drop <= drop_now;
            if (flush) begin
                bit_cnt <= '0;
            end else if (accept) begin
                sr      <= next_sr;
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (pop) begin
                dout       <= din ^ fifo_head;
                dout_valid <= 1'b1;
            end else if (dout_valid && dout_ready) begin
                dout_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ks_byte_cipher.sv
// Directed bench for ks_byte_cipher: packing order, saturation/drop, drain,
// backpressure, flush and mid-run reset, each against hand-computed values.
module tb_ks_byte_cipher;
    logic       clk = 1'b0;
    logic       rst;
    logic       ks_bit;
    logic       ks_valid;
    logic       flush;
    logic [7:0] din;
    logic       din_valid;
    logic       din_ready;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_ready;
    logic [2:0] fifo_count;
    logic       ks_drop;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q [$];

    ks_byte_cipher dut (
        .clk        (clk),
        .rst        (rst),
        .ks_bit     (ks_bit),
        .ks_valid   (ks_valid),
        .flush      (flush),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .fifo_count (fifo_count),
        .ks_drop    (ks_drop)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one byte worth of keystream, bit 0 first.
    task automatic feed_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            ks_valid = 1'b1;
            ks_bit   = b[i];
            step();
        end
        ks_valid = 1'b0;
        ks_bit   = 1'b0;
    endtask

    task automatic feed_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            ks_valid = 1'b1;
            ks_bit   = b[i];
            step();
        end
        ks_valid = 1'b0;
        ks_bit   = 1'b0;
    endtask

    task automatic xfer(input string tag, input logic [7:0] d, input logic [7:0] exp);
        din        = d;
        din_valid  = 1'b1;
        dout_ready = 1'b1;
        #1;
        check({tag, "_ready"}, {7'd0, din_ready}, 8'd1);
        step();
        din_valid = 1'b0;
        check({tag, "_dout"}, dout, exp);
        check({tag, "_dvalid"}, {7'd0, dout_valid}, 8'd1);
        step();
        check({tag, "_drained"}, {7'd0, dout_valid}, 8'd0);
    endtask

    logic [7:0] sat_bytes [5];
    logic [7:0] cur;
    logic [7:0] drain_exp [5];

    initial begin
        rst = 1'b1; ks_bit = 1'b0; ks_valid = 1'b0; flush = 1'b0;
        din = 8'h00; din_valid = 1'b0; dout_ready = 1'b0;
        step();
        din_valid = 1'b1;
        step();
        check("rst_dout", dout, 8'h00);
        check("rst_dvalid", {7'd0, dout_valid}, 8'd0);
        check("rst_count", {5'd0, fifo_count}, 8'd0);
        check("rst_drop", {7'd0, ks_drop}, 8'd0);
        check("rst_ready", {7'd0, din_ready}, 8'd0);
        din_valid = 1'b0;
        rst = 1'b0;

        // All-ones keystream XOR A5.
        feed_byte(8'hFF);
        check("ones_count", {5'd0, fifo_count}, 8'd1);
        xfer("ones", 8'hA5, 8'h5A);
        check("ones_count_after", {5'd0, fifo_count}, 8'd0);

        // Packing order: first bit lands in byte bit 0.
        feed_bits(8'h01, 8);
        xfer("lsb_first", 8'h00, 8'h01);
        feed_bits(8'h80, 8);
        xfer("msb_last", 8'h00, 8'h80);

        // Saturation with continuous keystream and no consumer.
        sat_bytes[0] = 8'h3C; sat_bytes[1] = 8'hC3; sat_bytes[2] = 8'h96;
        sat_bytes[3] = 8'h69; sat_bytes[4] = 8'h5A;
        for (int c = 1; c <= 44; c++) begin
            cur      = (c <= 40) ? sat_bytes[(c - 1) / 8] : sat_bytes[4];
            ks_valid = 1'b1;
            ks_bit   = (c <= 40) ? cur[(c - 1) % 8] : cur[7];
            step();
            if (c == 31) check("sat_count31", {5'd0, fifo_count}, 8'd3);
            if (c == 32) check("sat_count32", {5'd0, fifo_count}, 8'd4);
            if (c == 39) check("sat_nodrop39", {7'd0, ks_drop}, 8'd0);
            if (c == 40) check("sat_drop40", {7'd0, ks_drop}, 8'd1);
            if (c == 44) check("sat_drop44", {7'd0, ks_drop}, 8'd1);
        end
        check("sat_count_hold", {5'd0, fifo_count}, 8'd4);

        // Drain at full rate; first pop also absorbs the pending 8th bit.
        drain_exp[0] = 8'h33; drain_exp[1] = 8'hCC; drain_exp[2] = 8'h99;
        drain_exp[3] = 8'h66; drain_exp[4] = 8'h55;
        din = 8'h0F; din_valid = 1'b1; dout_ready = 1'b1;
        ks_valid = 1'b1; ks_bit = 1'b0;
        for (int p = 0; p < 5; p++) begin
            #1;
            check("drain_ready", {7'd0, din_ready}, 8'd1);
            step();
            ks_valid = 1'b0;
            check("drain_dout", dout, drain_exp[p]);
            check("drain_dvalid", {7'd0, dout_valid}, 8'd1);
            check("drain_count", {5'd0, fifo_count}, (p == 0) ? 8'd4 : 8'(4 - p));
            if (p == 0) check("drain_nodrop", {7'd0, ks_drop}, 8'd0);
        end
        check("drain_empty_ready", {7'd0, din_ready}, 8'd0);
        din_valid = 1'b0;
        step();
        check("drain_dvalid_end", {7'd0, dout_valid}, 8'd0);

        // Backpressure: output held stable, nothing lost or repeated.
        feed_byte(8'h12);
        feed_byte(8'h34);
        check("bp_count", {5'd0, fifo_count}, 8'd2);
        exp_q.push_back(8'hED);
        exp_q.push_back(8'hCB);
        din = 8'hFF; din_valid = 1'b1; dout_ready = 1'b1;
        step();
        dout_ready = 1'b0;
        cur = exp_q.pop_front();
        for (int h = 0; h < 5; h++) begin
            #1;
            check("bp_ready_low", {7'd0, din_ready}, 8'd0);
            check("bp_dout_stable", dout, cur);
            check("bp_dvalid", {7'd0, dout_valid}, 8'd1);
            step();
        end
        check("bp_count_hold", {5'd0, fifo_count}, 8'd1);
        dout_ready = 1'b1;
        #1;
        check("bp_release_ready", {7'd0, din_ready}, 8'd1);
        step();
        din_valid = 1'b0;
        cur = exp_q.pop_front();
        check("bp_second", dout, cur);
        step();
        check("bp_done", {7'd0, dout_valid}, 8'd0);
        check("bp_queue_empty", 8'(exp_q.size()), 8'd0);

        // Mid-byte flush while an output is still held.
        feed_byte(8'hA1);
        feed_byte(8'hB2);
        feed_byte(8'hC3);
        din = 8'h00; din_valid = 1'b1; dout_ready = 1'b0;
        step();
        din_valid = 1'b0;
        check("fl_pre_dout", dout, 8'hA1);
        feed_bits(8'hFF, 5);
        check("fl_pre_count", {5'd0, fifo_count}, 8'd2);
        flush = 1'b1; ks_valid = 1'b1; ks_bit = 1'b1; din_valid = 1'b1;
        #1;
        check("fl_ready_forced", {7'd0, din_ready}, 8'd0);
        step();
        flush = 1'b0; ks_valid = 1'b0; din_valid = 1'b0;
        check("fl_count", {5'd0, fifo_count}, 8'd0);
        check("fl_ready", {7'd0, din_ready}, 8'd0);
        check("fl_nodrop", {7'd0, ks_drop}, 8'd0);
        check("fl_dout_kept", dout, 8'hA1);
        check("fl_dvalid_kept", {7'd0, dout_valid}, 8'd1);
        dout_ready = 1'b1;
        step();
        check("fl_drained", {7'd0, dout_valid}, 8'd0);
        feed_bits(8'h81, 7);
        check("fl_partial", {5'd0, fifo_count}, 8'd0);
        feed_bits(8'h01, 1);
        check("fl_fresh_count", {5'd0, fifo_count}, 8'd1);
        xfer("fl_fresh", 8'h00, 8'h81);

        // Mid-run reset with buffered, partial and held data.
        feed_byte(8'h77);
        feed_byte(8'h88);
        din = 8'h00; din_valid = 1'b1; dout_ready = 1'b0;
        step();
        din_valid = 1'b0;
        check("mr_pre_dout", dout, 8'h77);
        feed_bits(8'hFF, 3);
        rst = 1'b1;
        step();
        check("mr_dout", dout, 8'h00);
        check("mr_dvalid", {7'd0, dout_valid}, 8'd0);
        check("mr_count", {5'd0, fifo_count}, 8'd0);
        check("mr_drop", {7'd0, ks_drop}, 8'd0);
        check("mr_ready", {7'd0, din_ready}, 8'd0);
        rst = 1'b0;
        feed_byte(8'h42);
        check("mr_fresh_count", {5'd0, fifo_count}, 8'd1);
        xfer("mr_fresh", 8'h00, 8'h42);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
